uart_tx_fifo_drain: RTL
=======================

Name: uart_tx_fifo_drain

Overview:
UART transmitter that sits directly downstream of the 8-entry FIFO in the user project and drains it. It pops one word at a time through the FIFO read interface, where read data is valid combinationally whenever the FIFO is non-empty. It serializes each word onto a single TX line as start bit, data bits LSB first, optional parity, and stop bits. The result goes to the UART pad.

Parameters:
DSIZE, 8, data bits per frame; must match the FIFO data width
CLKS_PER_BIT, 434, clk cycles per UART bit; minimum 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
CNT_W, 16, width of frames_sent counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits starting new frames; an in-flight frame always completes
fifo_rempty  input  1  FIFO empty flag
fifo_rdata  input  DSIZE  FIFO head word; valid while fifo_rempty=0
fifo_ren  output  1  FIFO pop strobe; combinational
tx  output  1  serial output; registered; idle high
busy  output  1  high from the capture edge until the FSM is back in IDLE
tx_done  output  1  single-cycle pulse at frame end
frames_sent  output  CNT_W  count of completed frames; wraps

Behaviour:
- Reset is rst_n, asynchronous, active-low. Clock is clk.
- Reset values: tx=1, busy=0, tx_done=0, frames_sent=0, FSM=IDLE, baud counter=0, bit index=0, shift register=0.
- fifo_ren = (state==IDLE) && enable && !fifo_rempty. No other term.
  - fifo_ren is never high outside IDLE.
  - fifo_ren is never high while fifo_rempty=1, so no underflow pops occur.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on the edge where fifo_ren=1 (the capture edge). On that edge:
  - shift register <= fifo_rdata;
  - parity bit computed as XOR of fifo_rdata, inverted when PARITY=2;
  - baud counter cleared;
  - busy <= 1.
- Bit timing: the baud counter runs 0..CLKS_PER_BIT-1. A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- START: tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after the capture edge. Then go to DATA.
- DATA: tx = shift[0] for each bit.
  - Shift right at each bit end.
  - The bit index counts 0..DSIZE-1.
  - After bit DSIZE-1: go to PARITY if PARITY!=0, else go to STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE. On that edge:
  - busy <= 0;
  - tx_done <= 1 for one cycle;
  - frames_sent increments by 1, wrapping from 2^CNT_W-1 to 0.
- tx is driven from registered state, so there are no glitches. tx=1 in IDLE.
- Frame length L = (1 + DSIZE + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles of line time.
- Back-to-back frames:
  - If the FIFO is non-empty and enable=1 on the first IDLE cycle, the next pop happens in that cycle.
  - Capture edges are therefore spaced exactly L+1 cycles apart. Exactly one idle-high cycle is added between frames.
- enable behaviour:
  - enable is sampled only in IDLE.
  - Deasserting enable mid-frame has no effect on the current frame.
  - Reasserting enable in IDLE with data present pops in that same cycle.
- The FIFO filling or emptying during a frame does not affect the frame, because data is already captured.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronously).
  - All state is cleared.
  - No tx_done is produced and frames_sent is not incremented.
  - The partially sent word is lost, and the FIFO is not re-read.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. FIFO holds 0xA5, enable=1.
   - Expected: fifo_ren high 1 cycle.
   - Expected tx: 4 cycles low, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high.
   - Expected: tx_done pulses 1 cycle 40 cycles after the capture edge; frames_sent=1.
2. Push 0x01, 0x02, 0x03 with enable=1.
   - Expected: three frames with capture edges exactly 41 cycles apart.
   - Expected: fifo_ren asserted exactly 3 times, never while fifo_rempty=1.
   - Expected: frames_sent=3, and the FIFO ends empty.
3. PARITY=1, then PARITY=2, STOP_BITS=2, word 0x07.
   - Expected: parity bit is 1 for even mode and 0 for odd mode.
   - Expected: the stop interval is 8 cycles high; L=48.
4. enable=0 with FIFO holding 0x55.
   - Expected: no pop, tx stays 1, busy=0.
   - Then raise enable: pop occurs in the same cycle.
   - Then drop enable in DATA: the frame completes normally, and no further pop occurs.
5. Assert rst_n=0 during DATA bit 3.
   - Expected: tx=1 and busy=0 immediately, frames_sent unchanged at 0, no tx_done.
   - After release with FIFO data present: the next word transmits correctly.
6. Preload frames_sent to 0xFFFF (CNT_W=16) by sending frames with a forced counter, then send one frame.
   - Expected: frames_sent wraps to 0x0000, and tx_done still pulses.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmitter that drains the upstream FIFO one word at a time. Each
// popped word is sent as a frame: start bit, DSIZE data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. The TX line idles high.
//
// Parameters:
//   DSIZE        data bits per frame (matches the FIFO data width, >= 2)
//   CLKS_PER_BIT clk cycles per UART bit (>= 2)
//   STOP_BITS    number of stop bits (1 or 2)
//   PARITY       0 = none, 1 = even, 2 = odd
//   CNT_W        width of the frames_sent counter
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       permits starting new frames; a frame in flight always completes
//   fifo_rempty  FIFO empty flag
//   fifo_rdata   FIFO head word, valid while fifo_rempty = 0
//   fifo_ren     FIFO pop strobe (combinational)
//   tx           serial output (registered, idle high)
//   busy         high from the capture edge until the FSM is back in IDLE
//   tx_done      one-cycle pulse at the end of each frame
//   frames_sent  count of completed frames, wraps
// ----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_rempty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIDX_W = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DSIZE - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY == 2);
    localparam logic              PAR_EN    = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY_S = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [BAUD_W-1:0]  baud_d;
    logic [BIDX_W-1:0]  bit_idx_q;
    logic               stop_idx_q;
    logic [DSIZE-1:0]   shift_q;
    logic [DSIZE-1:0]   shift_d;
    logic               parity_q;
    logic               tx_q;
    logic               busy_q;
    logic               tx_done_q;
    logic [CNT_W-1:0]   frames_q;
    logic               bit_end;

    // Pop only from IDLE, so the FIFO is never read mid-frame or when empty.
    assign fifo_ren = (state_q == IDLE) && enable && !fifo_rempty;

    assign bit_end = (baud_q == BAUD_LAST);
    assign baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
    assign shift_d = shift_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            frames_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_ren) begin
                        // Capture edge: latch the word and its parity; the
                        // start bit appears on the line from the next cycle.
                        state_q    <= START;
                        shift_q    <= fifo_rdata;
                        parity_q   <= (^fifo_rdata) ^ PAR_INV;
                        baud_q     <= '0;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_q       <= 1'b0;
                    end
                end

                START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end

                DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        shift_q <= shift_d;
                        if (bit_idx_q == BIDX_LAST) begin
                            bit_idx_q <= '0;
                            if (PAR_EN) begin
                                state_q <= PARITY_S;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + BIDX_W'(1);
                            tx_q      <= shift_d[0];
                        end
                    end
                end

                PARITY_S: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end

                STOP: begin
                    baud_q <= baud_d;
                    tx_q   <= 1'b1;
                    if (bit_end) begin
                        if (stop_idx_q == STOP_LAST) begin
                            state_q    <= IDLE;
                            stop_idx_q <= 1'b0;
                            busy_q     <= 1'b0;
                            tx_done_q  <= 1'b1;
                            frames_q   <= frames_q + CNT_W'(1);
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
    assign frames_sent = frames_q;

endmodule
